aes_loopback_checker: RTL
=========================

# aes_loopback_checker

Round-trip checker for the pipelined AES-128 encrypt→decrypt path. Captures every plaintext block launched into the encryptor, holds it in an in-order FIFO, and compares it with each block emitted by the decryptor. Reports pass and fail counts, a per-block mismatch pulse, and sticky protocol faults: overflow, underflow and latency timeout. It sits beside the encryptor/decryptor pair in the DFT top and serves as the receiving end for the plaintext stream.

## Interface
Parameters:
- DEPTH, 32: FIFO entries. Power of two, ≥ 2, ≥ maximum blocks in flight through enc+dec.
- CNT_W, 16: width of the pass/fail counters.
- TIMEOUT, 64: maximum cycles the FIFO may stay non-empty without an out_valid. Must be ≥ 1.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear of FIFO, counters, flags and state.
- in_valid  in  1  plaintext launched into the encryptor this cycle.
- in_data  in  128  plaintext block (PT).
- out_valid  in  1  decryptor output valid (dec valid_out).
- out_data  in  128  recovered plaintext (PT_Final).
- pass_cnt  out  CNT_W  matching blocks, saturating.
- fail_cnt  out  CNT_W  mismatching blocks, saturating.
- mismatch  out  1  one-cycle pulse per mismatching block.
- overflow  out  1  sticky: push while full without a pop.
- underflow  out  1  sticky: out_valid with an empty FIFO.
- timeout  out  1  sticky: latency watchdog expired.
- fault  out  1  high while the FSM is in FAULT.
- inflight  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FIFO: circular buffer with wr_ptr and rd_ptr ($clog2(DEPTH) bits, natural wrap) plus an occupancy count.
  - Push on in_valid, pop on out_valid.
  - Comparison always uses the head entry, so order is preserved.
- FSM states:
  - IDLE: count == 0.
  - BUSY: count > 0.
  - FAULT: entered on overflow, underflow or timeout.
- Transitions:
  - IDLE→BUSY on a push.
  - BUSY→IDLE when the count reaches 0.
  - Any state→FAULT on a fault event.
  - FAULT→IDLE only on clear.
- In FAULT:
  - FIFO pushes and pops still operate.
  - Compares and counters still update.
  - Watchdog is frozen.
- Compare: on a pop with count > 0 at cycle start:
  - out_data == head → pass_cnt += 1.
  - Otherwise → fail_cnt += 1 and mismatch pulses.
  - Counters saturate at 2^CNT_W−1.
- Simultaneous push and pop:
  - Count is unchanged.
  - Allowed when full.
  - The compare uses the pre-push head.
- Empty FIFO with push and pop in the same cycle:
  - Counts as underflow. The pushed block is still stored; no compare occurs.
- Push when full without a pop:
  - Block dropped, overflow set, pointers unchanged.
- Watchdog:
  - Counter resets to 0 on every pop and whenever count == 0.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT, timeout is set.
- clear:
  - Has priority over same-cycle in_valid and out_valid, which are ignored.
  - Empties the FIFO, zeroes all counters and flags, and sets state to IDLE.

## Timing
- Reset values:
  - pass_cnt = 0, fail_cnt = 0.
  - mismatch = 0, overflow = 0, underflow = 0, timeout = 0, fault = 0.
  - inflight = 0.
  - FSM = IDLE, pointers = 0.
- All outputs are registered.
  - Stimulus in cycle N is visible in cycle N+1, covering counters, mismatch, flags and inflight.
- Sticky flags and fault take effect one cycle after the event.
- FIFO storage needs no reset; only pointers and count are reset.
- Asserting rst mid-stream drops all in-flight entries immediately (asynchronous).
- Throughput: one push and one pop per cycle, no stalls, no backpressure.
- Timeout sets exactly TIMEOUT+1 cycles after the last pop (or the first push into an empty FIFO) when no out_valid follows.

## Test plan
- FIPS-197 round trip:
  - Stimulus: push 00112233445566778899aabbccddeeff; 20 cycles later, out_data equal to it.
  - Required: pass_cnt=1, fail_cnt=0, inflight returns 0, FSM back in IDLE.
- Burst order check:
  - Stimulus: push 32 back-to-back blocks (i=0..31); pop the same sequence starting cycle 12.
  - Required: pass_cnt=32, no flags set.
  - Variant: swap blocks 5 and 6 on the return path → fail_cnt=2, two mismatch pulses.
- Full boundary:
  - Stimulus: fill to 32, then push+pop in the same cycle → inflight stays 32, no overflow.
  - Stimulus: push alone while full → overflow=1 and fault=1 next cycle; the dropped block is never compared.
- Underflow:
  - Stimulus: out_valid with an empty FIFO.
  - Required: underflow=1, fault=1, counters unchanged.
  - Then clear → all outputs 0, FSM in IDLE.
- Watchdog:
  - Stimulus: push one block and withhold out_valid.
  - Required: timeout asserts exactly 65 cycles after the push (TIMEOUT=64).
  - A pop at cycle 64 keeps timeout=0.
- Reset mid-stream:
  - Stimulus: 10 blocks in flight; pulse rst asynchronously.
  - Required: inflight=0 and counters=0 immediately.
  - A subsequent pop flags underflow.

Source files
------------

// File: rtl/aes_loopback_checker.sv
`default_nettype none
// ============================================================================
// Module      : aes_loopback_checker
// Description : Round-trip checker for the AES-128 encrypt->decrypt path.
//               Queues launched plaintext in order and compares it against
//               the decryptor output, with sticky protocol fault detection.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_loopback_checker #(
   parameter int DEPTH   = 32,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       in_valid,
   input  logic [127:0]               in_data,
   input  logic                       out_valid,
   input  logic [127:0]               out_data,
   output logic [CNT_W-1:0]           pass_cnt,
   output logic [CNT_W-1:0]           fail_cnt,
   output logic                       mismatch,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       timeout,
   output logic                       fault,
   output logic [$clog2(DEPTH):0]     inflight
);

   localparam int                  c_ADDR_W   = $clog2(DEPTH);
   localparam int                  c_WD_W     = $clog2(TIMEOUT + 1);
   localparam logic [c_ADDR_W:0]   c_FULL     = (c_ADDR_W + 1)'(DEPTH);
   localparam logic [c_WD_W-1:0]   c_WD_LIMIT = c_WD_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t                r_state;
   logic [127:0]          r_mem [DEPTH];
   logic [c_ADDR_W-1:0]   r_wr_ptr;
   logic [c_ADDR_W-1:0]   r_rd_ptr;
   logic [c_ADDR_W:0]     r_count;
   logic [c_WD_W-1:0]     r_wd;
   logic [CNT_W-1:0]      r_pass_cnt;
   logic [CNT_W-1:0]      r_fail_cnt;
   logic                  r_mismatch;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_timeout;
   logic                  r_fault;

   logic                  w_push_req;
   logic                  w_pop_req;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_do_push;
   logic                  w_do_pop;
   logic                  w_unf_ev;
   logic                  w_ovf_ev;
   logic                  w_to_ev;
   logic                  w_fault_ev;
   logic                  w_match;
   logic [c_WD_W-1:0]     w_wd_inc;
   logic [c_ADDR_W:0]     w_count_next;

   assign w_push_req = in_valid  & ~clear;
   assign w_pop_req  = out_valid & ~clear;
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == c_FULL);

   // A pop on an empty FIFO is an underflow; any same-cycle push still lands.
   assign w_unf_ev   = w_pop_req & w_empty;
   assign w_do_pop   = w_pop_req & ~w_empty;
   assign w_ovf_ev   = w_push_req & w_full & ~w_pop_req;
   assign w_do_push  = w_push_req & ~w_ovf_ev;

   // Head is read before this cycle's write, so push+pop when full compares the old head.
   assign w_match    = (out_data == r_mem[r_rd_ptr]);

   assign w_wd_inc   = r_wd + 1'b1;
   assign w_to_ev    = (r_state != S_FAULT) & ~w_empty & ~w_do_pop & (w_wd_inc == c_WD_LIMIT);
   assign w_fault_ev = w_unf_ev | w_ovf_ev | w_to_ev;

   always_comb begin
      w_count_next = r_count;
      case ({w_do_push, w_do_pop})
         2'b10:   w_count_next = r_count + 1'b1;
         2'b01:   w_count_next = r_count - 1'b1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_wd        <= '0;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
         r_mismatch  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_timeout   <= 1'b0;
         r_fault     <= 1'b0;
      end else if (clear) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_wd        <= '0;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
         r_mismatch  <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_timeout   <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;

         r_mismatch <= w_do_pop & ~w_match;
         if (w_do_pop && w_match && (r_pass_cnt != c_CNT_MAX)) begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
         end
         if (w_do_pop && !w_match && (r_fail_cnt != c_CNT_MAX)) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
         end

         r_overflow  <= r_overflow  | w_ovf_ev;
         r_underflow <= r_underflow | w_unf_ev;
         r_timeout   <= r_timeout   | w_to_ev;
         r_fault     <= r_fault     | w_fault_ev;

         // Watchdog holds its value once faulted; only clear or rst restarts it.
         if (r_state != S_FAULT) begin
            if (w_do_pop || w_empty) begin
               r_wd <= '0;
            end else begin
               r_wd <= w_wd_inc;
            end
         end

         if (w_fault_ev) begin
            r_state <= S_FAULT;
         end else begin
            case (r_state)
               S_IDLE:  if (w_count_next != '0) r_state <= S_BUSY;
               S_BUSY:  if (w_count_next == '0) r_state <= S_IDLE;
               S_FAULT: r_state <= S_FAULT;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign pass_cnt  = r_pass_cnt;
   assign fail_cnt  = r_fail_cnt;
   assign mismatch  = r_mismatch;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;
   assign timeout   = r_timeout;
   assign fault     = r_fault;
   assign inflight  = r_count;

endmodule
`default_nettype wire
